cond_exec_stage: RTL



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cond_check.sv | 52 +++++
 rtl/cond_exec_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared condition-code and flag-index constants
// Purpose: ARM condition field encodings and NZCV bit positions used by the
//          execute-stage condition logic.
// Ports:   none (package)
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluator
// Purpose: decide whether the Execute instruction runs, from the registered
//          NZCV flags and its 4-bit condition field.
// Ports:   CondE   in  4  condition field
//          Flags   in  4  registered {N,Z,C,V}
//          CondExE out 1  condition passed
// Config:  COND_NV_ALWAYS_EN - when defined, condition 1111 passes;
//          otherwise 1111 never executes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] Flags,
  output logic       CondExE
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~c | z;
      COND_GE: CondExE = ge;
      COND_LT: CondExE = ~ge;
      COND_GT: CondExE = ~z & ge;
      COND_LE: CondExE = z | ~ge;
      COND_AL: CondExE = 1'b1;
`ifdef COND_NV_ALWAYS_EN
      COND_NV: CondExE = 1'b1;
`else
      COND_NV: CondExE = 1'b0;
`endif
      default: CondExE = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - execute-stage condition unit, NZCV flags and EX/MEM register
// Purpose: gates Execute-stage side effects on the condition result, keeps the
//          architectural flags, and registers surviving results into Memory.
// Ports:   clk, reset (sync active-high); StallM, FlushM pipeline controls
//          CondE, FlagWriteE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE,
//          ALUFlags, ALUResultE, WriteDataE, WA3E  - Execute-stage inputs
//          CondExE, BranchTakenE, PCSrcGatedE       - combinational gates
//          Flags                                    - registered NZCV
//          RegWriteM, MemWriteM, MemtoRegM, PCSrcM, ALUOutM, WriteDataM, WA3M
// Config:  COND_NV_ALWAYS_EN (see cond_check) selects the behaviour of cond 1111.
module cond_exec_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic             BranchE,
  input  logic [3:0]       ALUFlags,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [RA_W-1:0]  WA3E,
  output logic             BranchTakenE,
  output logic             PCSrcGatedE,
  output logic             CondExE,
  output logic [3:0]       Flags,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RA_W-1:0]  WA3M
);

  logic advance;

  cond_check u_cond_check (
    .CondE   (CondE),
    .Flags   (Flags),
    .CondExE (CondExE)
  );

  assign BranchTakenE = BranchE & CondExE;
  assign PCSrcGatedE  = PCSrcE & CondExE;

  // A flushed instruction never reaches Memory, so it must not touch flags either.
  assign advance = ~StallM & ~FlushM;

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (advance && CondExE) begin
      if (FlagWriteE[1]) begin
        Flags[FLAG_N] <= ALUFlags[FLAG_N];
        Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagWriteE[0]) begin
        Flags[FLAG_C] <= ALUFlags[FLAG_C];
        Flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (StallM) begin
      // hold everything, including when FlushM is also asserted
    end else if (FlushM) begin
      // bubble: only control bits cleared, data fields are don't-care and hold
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE & CondExE;
      MemWriteM  <= MemWriteE & CondExE;
      MemtoRegM  <= MemtoRegE;
      PCSrcM     <= PCSrcE & CondExE;
      ALUOutM    <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
    end
  end

endmodule
